reg_bank_sb: RTL and testbench

- Register storage bank with per-entry scoreboard; sits directly upstream of the register-select mux.
- Holds DEPTH registers of BIT_WIDTH bits and presents all of them on one packed bus that the mux consumes as its data input.
- Tracks a busy bit per register: set on instruction issue, cleared on writeback. The hazard logic uses these bits to stall.
- Entry 0 can be hard-wired to zero, matching the MIPS r0 convention.

---
 rtl/reg_bank_sb.sv | 93 +++++++++
 tb/tb_reg_bank_sb.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/reg_bank_sb.sv
// reg_bank_sb: register storage bank with a per-entry busy scoreboard.
// All DEPTH entries are presented on one packed bus for the downstream
// register-select mux. Busy bits are set on issue and cleared on writeback;
// a writeback to a non-busy entry raises a sticky wr_err.
// Optional feature macro: REG_BANK_BYPASS_EN (same-cycle write-through on regs_out).
module reg_bank_sb #(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SEL_WIDTH = $clog2(DEPTH),
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_n,
  input  logic                       wr_en,
  input  logic [SEL_WIDTH-1:0]       wr_addr,
  input  logic [BIT_WIDTH-1:0]       wr_data,
  input  logic                       iss_en,
  input  logic [SEL_WIDTH-1:0]       iss_addr,
  output logic [BIT_WIDTH*DEPTH-1:0] regs_out,
  output logic [DEPTH-1:0]           busy,
  output logic                       wr_err
);

  localparam logic [SEL_WIDTH:0] DEPTH_L = (SEL_WIDTH+1)'(DEPTH);
  localparam bit                 ZERO_EN = (ZERO_REG != 0);

  logic [BIT_WIDTH-1:0] regs_q [DEPTH];
  logic [BIT_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]     busy_q, busy_d;
  logic                 wr_err_q, wr_err_d;
  logic                 wr_ok, iss_ok;

  // Qualify strobes: enabled, address in range, not the hard-wired zero entry.
  always_comb begin
    wr_ok  = !en_n && wr_en && ({1'b0, wr_addr} < DEPTH_L)
             && !(ZERO_EN && (wr_addr == '0));
    iss_ok = !en_n && iss_en && ({1'b0, iss_addr} < DEPTH_L)
             && !(ZERO_EN && (iss_addr == '0));
  end

  // Next-state: writeback updates data and clears busy; issue is applied
  // afterwards so a same-address issue keeps the entry busy.
  always_comb begin
    regs_d   = regs_q;
    busy_d   = busy_q;
    wr_err_d = wr_err_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
      if (!busy_q[wr_addr]) begin
        wr_err_d = 1'b1;
      end
    end
    if (iss_ok) begin
      busy_d[iss_addr] = 1'b1;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q   <= '{default: '0};
      busy_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Pack storage onto the output bus, optionally forwarding the in-flight write.
  always_comb begin
    regs_out = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_out[BIT_WIDTH*i +: BIT_WIDTH] = regs_q[i];
`ifdef REG_BANK_BYPASS_EN
      if (wr_ok && (wr_addr == SEL_WIDTH'(i))) begin
        regs_out[BIT_WIDTH*i +: BIT_WIDTH] = wr_data;
      end
`else
`endif
      if (ZERO_EN && (i == 0)) begin
        regs_out[BIT_WIDTH*i +: BIT_WIDTH] = '0;
      end
    end
  end

  assign busy   = busy_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_reg_bank_sb.sv
// Scoreboard bench for reg_bank_sb: two instances (ZERO_REG=1 and ZERO_REG=0)
// share stimulus; expected state is queued by the stimulus and checked by a
// monitor on the falling edge.
module tb_reg_bank_sb;

  logic        clk = 1'b0;
  logic        rst, en_n, wr_en, iss_en;
  logic [1:0]  wr_addr, iss_addr;
  logic [3:0]  wr_data;
  logic [15:0] regs_a, regs_b;
  logic [3:0]  busy_a, busy_b;
  logic        err_a, err_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [15:0] ra;
    logic [3:0]  ba;
    logic        ea;
    logic [15:0] rb;
    logic [3:0]  bb;
    logic        eb;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  reg_bank_sb #(.BIT_WIDTH(4), .DEPTH(4), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .en_n(en_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .regs_out(regs_a), .busy(busy_a), .wr_err(err_a)
  );

  reg_bank_sb #(.BIT_WIDTH(4), .DEPTH(4), .ZERO_REG(0)) u_dut_nz (
    .clk(clk), .rst(rst), .en_n(en_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .regs_out(regs_b), .busy(busy_b), .wr_err(err_b)
  );

  task automatic chk(input string nm, input string fld, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "regs_a", regs_a, e.ra);
      chk(e.name, "busy_a", {12'h0, busy_a}, {12'h0, e.ba});
      chk(e.name, "err_a",  {15'h0, err_a},  {15'h0, e.ea});
      chk(e.name, "regs_b", regs_b, e.rb);
      chk(e.name, "busy_b", {12'h0, busy_b}, {12'h0, e.bb});
      chk(e.name, "err_b",  {15'h0, err_b},  {15'h0, e.eb});
    end
  end

  task automatic drive(input logic r, input logic n, input logic we,
                       input logic [1:0] wa, input logic [3:0] wd,
                       input logic ie, input logic [1:0] ia);
    rst = r; en_n = n; wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
  endtask

  task automatic expect_now(input string nm, input logic [15:0] ra,
                            input logic [3:0] ba, input logic ea,
                            input logic [15:0] rb, input logic [3:0] bb,
                            input logic eb);
    exp_t e;
    e.name = nm; e.ra = ra; e.ba = ba; e.ea = ea;
    e.rb = rb; e.bb = bb; e.eb = eb;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0);
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_now("reset", 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2); tick();
    expect_now("issue2", 16'h0000, 4'b0100, 1'b0, 16'h0000, 4'b0100, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0); tick();
    expect_now("idle1", 16'h0000, 4'b0100, 1'b0, 16'h0000, 4'b0100, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 2'd2, 4'hA, 1'b0, 2'd0); tick();
    expect_now("write2", 16'h0A00, 4'b0000, 1'b0, 16'h0A00, 4'b0000, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd1); tick();
    expect_now("issue1", 16'h0A00, 4'b0010, 1'b0, 16'h0A00, 4'b0010, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 4'h5, 1'b1, 2'd1); tick();
    expect_now("collide1", 16'h0A50, 4'b0010, 1'b0, 16'h0A50, 4'b0010, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd0); tick();
    expect_now("issue0", 16'h0A50, 4'b0010, 1'b0, 16'h0A50, 4'b0011, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 2'd0); tick();
    expect_now("write0", 16'h0A50, 4'b0010, 1'b0, 16'h0A5F, 4'b0010, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 2'd3, 4'h7, 1'b0, 2'd0); tick();
    expect_now("disabled", 16'h0A50, 4'b0010, 1'b0, 16'h0A5F, 4'b0010, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 2'd3, 4'h7, 1'b0, 2'd0); tick();
    expect_now("wr_err", 16'h7A50, 4'b0010, 1'b1, 16'h7A5F, 4'b0010, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0); tick();
    expect_now("err_hold", 16'h7A50, 4'b0010, 1'b1, 16'h7A5F, 4'b0010, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 4'hC, 1'b0, 2'd0);
`ifdef REG_BANK_BYPASS_EN
    expect_now("bypass_same", 16'h7AC0, 4'b0010, 1'b1, 16'h7ACF, 4'b0010, 1'b1);
`else
    expect_now("bypass_same", 16'h7A50, 4'b0010, 1'b1, 16'h7A5F, 4'b0010, 1'b1);
`endif
    tick();
    expect_now("bypass_next", 16'h7AC0, 4'b0000, 1'b1, 16'h7ACF, 4'b0000, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 4'h3, 1'b1, 2'd2); tick();
    expect_now("split_wr_iss", 16'h7A30, 4'b0100, 1'b1, 16'h7A3F, 4'b0100, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2); tick();
    expect_now("reissue", 16'h7A30, 4'b0100, 1'b1, 16'h7A3F, 4'b0100, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 4'h9, 1'b1, 2'd3); tick();
    expect_now("rst_mid", 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0); tick();
    expect_now("post_rst", 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
